// File: rtl/mac_burst_driver_if.sv
// Host-load, MAC-side and result-handshake signals of mac_burst_driver.
// master is the driver itself; slave is the host/MAC environment.
interface mac_burst_driver_if;
    logic       ld_valid;
    logic       ld_ready;
    logic [3:0] ld_a;
    logic [3:0] ld_b;
    logic       in_valid;
    logic [3:0] in1_IFM;
    logic [3:0] in2_IFM;
    logic       out_valid;
    logic [9:0] out;
    logic       res_valid;
    logic       res_ready;
    logic [9:0] res_data;
    logic       err_timeout;

    modport master (
        input  ld_valid, ld_a, ld_b, out_valid, out, res_ready,
        output ld_ready, in_valid, in1_IFM, in2_IFM, res_valid, res_data, err_timeout
    );

    modport slave (
        output ld_valid, ld_a, ld_b, out_valid, out, res_ready,
        input  ld_ready, in_valid, in1_IFM, in2_IFM, res_valid, res_data, err_timeout
    );
endinterface

// File: rtl/mac_burst_driver.sv
// Buffers host operand pairs and feeds them to a MAC in bursts of BURST, then returns the result.
// Define MAC_DRV_CHECK_EN to add a local accumulator and the err_mismatch output.
module mac_burst_driver #(
    parameter int unsigned BURST   = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mac_burst_driver_if.master     bus
`ifdef MAC_DRV_CHECK_EN
    ,
    output logic                   err_mismatch
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic              in_valid_q, in_valid_d;
    logic [3:0]        in1_q, in1_d, in2_q, in2_d;
    logic              res_valid_q, res_valid_d;
    logic [9:0]        res_data_q, res_data_d;
    logic              err_timeout_q, err_timeout_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [7:0]        mem_q [DEPTH];
    logic              push, pop, ld_ready;
    logic [3:0]        head_a, head_b;
    logic [9:0]        prod;

    assign head_a   = mem_q[rd_ptr_q][7:4];
    assign head_b   = mem_q[rd_ptr_q][3:0];
    assign prod     = {6'd0, head_a} * {6'd0, head_b};
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign ld_ready = (count_q != CntW'(DEPTH)) || pop;
    assign push     = bus.ld_valid && ld_ready;

`ifdef MAC_DRV_CHECK_EN
    logic [9:0] acc_q, acc_d;
    logic       err_mismatch_q, err_mismatch_d;
`endif

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        timer_d       = timer_q;
        in_valid_d    = 1'b0;
        in1_d         = '0;
        in2_d         = '0;
        pop           = 1'b0;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        err_timeout_d = err_timeout_q;
`ifdef MAC_DRV_CHECK_EN
        acc_d          = acc_q;
        err_mismatch_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (count_q >= CntW'(BURST) && !res_valid_q) begin
                    state_d    = StSend;
                    beat_d     = '0;
                    pop        = 1'b1;
                    in_valid_d = 1'b1;
                    in1_d      = head_a;
                    in2_d      = head_b;
`ifdef MAC_DRV_CHECK_EN
                    acc_d      = prod;
`endif
                end
            end
            StSend: begin
                // Pops run one cycle ahead of the registered in_valid beats.
                if (beat_q == 2'(BURST - 1)) begin
                    state_d = StWait;
                    timer_d = '0;
                end else begin
                    beat_d     = beat_q + 2'd1;
                    pop        = 1'b1;
                    in_valid_d = 1'b1;
                    in1_d      = head_a;
                    in2_d      = head_b;
`ifdef MAC_DRV_CHECK_EN
                    acc_d      = acc_q + prod;
`endif
                end
            end
            StWait: begin
                if (bus.out_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = bus.out;
                    state_d     = StHold;
`ifdef MAC_DRV_CHECK_EN
                    err_mismatch_d = (bus.out != acc_q);
`endif
                end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StHold: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.ld_a, bus.ld_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            beat_q        <= '0;
            timer_q       <= '0;
            in_valid_q    <= 1'b0;
            in1_q         <= '0;
            in2_q         <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            err_timeout_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            timer_q       <= timer_d;
            in_valid_q    <= in_valid_d;
            in1_q         <= in1_d;
            in2_q         <= in2_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            err_timeout_q <= err_timeout_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

`ifdef MAC_DRV_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q          <= '0;
            err_mismatch_q <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            err_mismatch_q <= err_mismatch_d;
        end
    end

    assign err_mismatch = err_mismatch_q;
`endif

    assign bus.ld_ready    = ld_ready;
    assign bus.in_valid    = in_valid_q;
    assign bus.in1_IFM     = in1_q;
    assign bus.in2_IFM     = in2_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.err_timeout = err_timeout_q;

endmodule
